// File: rtl/vga_timing_gen.sv
// Parametrised VESA-style raster timing generator with one-pixel counter lookahead.
// Optional vertical-blank interrupt enabled by defining VTG_VBLANK_IRQ_EN.
module vga_timing_gen #(
   parameter int unsigned CW     = 12,
   parameter int unsigned H_VIS  = 800,
   parameter int unsigned H_FP   = 40,
   parameter int unsigned H_SYNC = 128,
   parameter int unsigned H_BP   = 88,
   parameter int unsigned V_VIS  = 600,
   parameter int unsigned V_FP   = 1,
   parameter int unsigned V_SYNC = 4,
   parameter int unsigned V_BP   = 23,
   parameter bit          H_POL  = 1'b1,
   parameter bit          V_POL  = 1'b1
) (
   input  logic          clk,
   input  logic          nrst,
   input  logic          ce,
   input  logic          irq_ack,
   output logic [CW-1:0] hcount,
   output logic [CW-1:0] vcount,
   output logic          hsync,
   output logic          vsync,
   output logic          de,
   output logic          line_start,
   output logic          frame_start,
   output logic          irq
);

   localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

   localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_VIS_C  = CW'(H_VIS);
   localparam logic [CW-1:0] V_VIS_C  = CW'(V_VIS);
   localparam logic [CW-1:0] HS_START = CW'(H_VIS + H_FP);
   localparam logic [CW-1:0] HS_END   = CW'(H_VIS + H_FP + H_SYNC);
   localparam logic [CW-1:0] VS_START = CW'(V_VIS + V_FP);
   localparam logic [CW-1:0] VS_END   = CW'(V_VIS + V_FP + V_SYNC);

   logic [CW-1:0] hcount_q, hcount_d;
   logic [CW-1:0] vcount_q, vcount_d;
   logic          hsync_q, hsync_d;
   logic          vsync_q, vsync_d;
   logic          de_q, de_d;
   logic          ls_q, ls_d;
   logic          fs_q, fs_d;

   // Outputs for pixel (x,y) are derived from the pre-update counters, so they
   // trail hcount/vcount by exactly one ce cycle.
   always_comb begin
      hcount_d = hcount_q;
      vcount_d = vcount_q;
      hsync_d  = hsync_q;
      vsync_d  = vsync_q;
      de_d     = de_q;
      ls_d     = 1'b0;
      fs_d     = 1'b0;
      if (ce) begin
         if (hcount_q == H_LAST) begin
            hcount_d = '0;
            vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 1'b1;
         end else begin
            hcount_d = hcount_q + 1'b1;
         end
         de_d    = (hcount_q < H_VIS_C) && (vcount_q < V_VIS_C);
         hsync_d = ((hcount_q >= HS_START) && (hcount_q < HS_END)) ? H_POL : ~H_POL;
         vsync_d = ((vcount_q >= VS_START) && (vcount_q < VS_END)) ? V_POL : ~V_POL;
         ls_d    = (hcount_q == '0);
         fs_d    = (hcount_q == '0) && (vcount_q == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         hcount_q <= '0;
         vcount_q <= '0;
         hsync_q  <= ~H_POL;
         vsync_q  <= ~V_POL;
         de_q     <= 1'b0;
         ls_q     <= 1'b0;
         fs_q     <= 1'b0;
      end else begin
         hcount_q <= hcount_d;
         vcount_q <= vcount_d;
         hsync_q  <= hsync_d;
         vsync_q  <= vsync_d;
         de_q     <= de_d;
         ls_q     <= ls_d;
         fs_q     <= fs_d;
      end
   end

   assign hcount      = hcount_q;
   assign vcount      = vcount_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign de          = de_q;
   assign line_start  = ls_q;
   assign frame_start = fs_q;

`ifdef VTG_VBLANK_IRQ_EN
   logic irq_q, irq_d;
   logic irq_set;

   // Set has priority over acknowledge; the clear does not wait for ce.
   always_comb begin
      irq_set = ce && (hcount_q == H_LAST) && (vcount_q == CW'(V_VIS - 1));
      irq_d   = irq_set | (irq_q & ~irq_ack);
   end

   always_ff @(posedge clk) begin
      if (!nrst) irq_q <= 1'b0;
      else       irq_q <= irq_d;
   end

   assign irq = irq_q;
`else
   logic unused_irq_ack;
   assign unused_irq_ack = irq_ack;
   assign irq            = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen using a reduced 16x8 raster so full frames stay short.
// Instance A: active-high syncs, ce under test control; instance B: active-low syncs, ce toggling.
module tb_vga_timing_gen;

   logic       clk = 1'b0;
   logic       nrst = 1'b0;
   logic       ce_a = 1'b0, ack_a = 1'b0, ce_b = 1'b0;
   logic [3:0] a_h, a_v, b_h, b_v;
   logic       a_hs, a_vs, a_de, a_ls, a_fs, a_irq;
   logic       b_hs, b_vs, b_de, b_ls, b_fs, b_irq;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   // H: 8 vis, fp 2, sync 3, bp 3 -> 16 (exactly 2^CW); V: 4 vis, fp 1, sync 2, bp 1 -> 8
   vga_timing_gen #(.CW(4), .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                    .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                    .H_POL(1'b1), .V_POL(1'b1)) dut_a (
      .clk(clk), .nrst(nrst), .ce(ce_a), .irq_ack(ack_a),
      .hcount(a_h), .vcount(a_v), .hsync(a_hs), .vsync(a_vs), .de(a_de),
      .line_start(a_ls), .frame_start(a_fs), .irq(a_irq));

   vga_timing_gen #(.CW(4), .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                    .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                    .H_POL(1'b0), .V_POL(1'b0)) dut_b (
      .clk(clk), .nrst(nrst), .ce(ce_b), .irq_ack(1'b0),
      .hcount(b_h), .vcount(b_v), .hsync(b_hs), .vsync(b_vs), .de(b_de),
      .line_start(b_ls), .frame_start(b_fs), .irq(b_irq));

   typedef struct {
      logic       rn, ce;
      logic [3:0] h, v;
      logic       hs, vs, de, ls, fs;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic rn, input logic c, input int h, input int v,
                      input logic hs, input logic vs, input logic de,
                      input logic ls, input logic fs);
      vec_t r;
      r.rn = rn; r.ce = c; r.h = 4'(h); r.v = 4'(v);
      r.hs = hs; r.vs = vs; r.de = de; r.ls = ls; r.fs = fs;
      tbl.push_back(r);
   endtask

   initial begin
      int last_ls, last_fs, hs_rise, vs_rise, de_cnt, nfs, ls_rise;
      logic prev_hs, prev_vs, prev_ls;
      bit found;

      //  rn ce  h  v  hs vs de ls fs
      add(0, 1,  0, 0, 0, 0, 0, 0, 0);
      add(0, 0,  0, 0, 0, 0, 0, 0, 0);
      add(1, 1,  1, 0, 0, 0, 1, 1, 1);   // pixel (0,0)
      add(1, 0,  1, 0, 0, 0, 1, 0, 0);   // hold, strobes drop
      add(1, 1,  2, 0, 0, 0, 1, 0, 0);
      add(1, 1,  3, 0, 0, 0, 1, 0, 0);
      add(1, 1,  4, 0, 0, 0, 1, 0, 0);
      add(1, 1,  5, 0, 0, 0, 1, 0, 0);
      add(1, 1,  6, 0, 0, 0, 1, 0, 0);
      add(1, 1,  7, 0, 0, 0, 1, 0, 0);
      add(1, 1,  8, 0, 0, 0, 1, 0, 0);   // pixel 7, last visible
      add(1, 1,  9, 0, 0, 0, 0, 0, 0);   // pixel 8
      add(1, 1, 10, 0, 0, 0, 0, 0, 0);   // pixel 9
      add(1, 1, 11, 0, 1, 0, 0, 0, 0);   // pixel 10, hsync starts
      add(1, 1, 12, 0, 1, 0, 0, 0, 0);
      add(1, 0, 12, 0, 1, 0, 0, 0, 0);   // hold inside sync
      add(1, 1, 13, 0, 1, 0, 0, 0, 0);   // pixel 12, last sync
      add(1, 1, 14, 0, 0, 0, 0, 0, 0);   // pixel 13
      add(1, 1, 15, 0, 0, 0, 0, 0, 0);
      add(1, 1,  0, 1, 0, 0, 0, 0, 0);   // pixel 15 wraps line
      add(1, 1,  1, 1, 0, 0, 1, 1, 0);   // pixel (0,1)
      add(0, 1,  0, 0, 0, 0, 0, 0, 0);   // reset beats ce
      add(1, 1,  1, 0, 0, 0, 1, 1, 1);

      for (int i = 0; i < tbl.size(); i++) begin
         nrst = tbl[i].rn;
         ce_a = tbl[i].ce;
         tick();
         chk($sformatf("v%0d_h", i),  a_h,  tbl[i].h);
         chk($sformatf("v%0d_v", i),  a_v,  tbl[i].v);
         chk($sformatf("v%0d_hs", i), a_hs, tbl[i].hs);
         chk($sformatf("v%0d_vs", i), a_vs, tbl[i].vs);
         chk($sformatf("v%0d_de", i), a_de, tbl[i].de);
         chk($sformatf("v%0d_ls", i), a_ls, tbl[i].ls);
         chk($sformatf("v%0d_fs", i), a_fs, tbl[i].fs);
         chk($sformatf("v%0d_irq", i), a_irq, 0);
      end

      // Mid-frame reset inside both sync pulses
      nrst = 1'b0; ce_a = 1'b1; tick();
      nrst = 1'b1;
      found = 0;
      for (int c = 0; c < 200 && !found; c++) begin
         tick();
         if (a_h == 4'd12 && a_v == 4'd5) found = 1;
      end
      chk("midframe_found", int'(found), 1);
      chk("midframe_hs", a_hs, 1);
      chk("midframe_vs", a_vs, 1);
      nrst = 1'b0; tick();
      chk("rst_h", a_h, 0);
      chk("rst_v", a_v, 0);
      chk("rst_de", a_de, 0);
      chk("rst_hs", a_hs, 0);
      chk("rst_vs", a_vs, 0);
      chk("rst_fs", a_fs, 0);

      // Free-running periods, ce=1
      nrst = 1'b1; ce_a = 1'b1;
      last_ls = -1; last_fs = -1; hs_rise = 0; vs_rise = 0; de_cnt = 0; nfs = 0;
      prev_hs = 1'b0; prev_vs = 1'b0;
      for (int c = 1; c <= 260; c++) begin
         tick();
         if (a_ls) begin
            if (last_ls >= 0) chk("ls_period", c - last_ls, 16);
            last_ls = c;
         end
         if (a_fs) begin
            if (last_fs >= 0) chk("fs_period", c - last_fs, 128);
            last_fs = c; nfs++;
         end
         if (a_hs && !prev_hs) begin chk("hs_offset", c - last_ls, 10); hs_rise = c; end
         if (!a_hs && prev_hs) chk("hs_width", c - hs_rise, 3);
         if (a_vs && !prev_vs) begin chk("vs_offset", c - last_fs, 80); vs_rise = c; end
         if (!a_vs && prev_vs) chk("vs_width", c - vs_rise, 32);
         if (c <= 128 && a_de) de_cnt++;
`ifndef VTG_VBLANK_IRQ_EN
         chk("irq_off", a_irq, 0);
`endif
         prev_hs = a_hs; prev_vs = a_vs;
      end
      chk("de_per_frame", de_cnt, 32);
      chk("fs_count", nfs, 3);
      ce_a = 1'b0;

      // Instance B: ce every other clk, active-low syncs
      nrst = 1'b0; tick();
      chk("b_rst_hs", b_hs, 1);
      chk("b_rst_vs", b_vs, 1);
      nrst = 1'b1;
      last_ls = -1; last_fs = -1; hs_rise = 0; vs_rise = 0; nfs = 0; ls_rise = 0;
      prev_hs = 1'b1; prev_vs = 1'b1; prev_ls = 1'b0;
      for (int c = 1; c <= 520; c++) begin
         ce_b = c[0];
         tick();
         if (b_ls && !prev_ls) begin
            if (last_ls >= 0) chk("b_ls_period", c - last_ls, 32);
            last_ls = c; ls_rise = c;
         end
         if (!b_ls && prev_ls) chk("b_ls_width", c - ls_rise, 1);
         if (b_fs) begin
            if (last_fs >= 0) chk("b_fs_period", c - last_fs, 256);
            last_fs = c; nfs++;
         end
         if (!b_hs && prev_hs) begin chk("b_hs_offset", c - last_ls, 20); hs_rise = c; end
         if (b_hs && !prev_hs) chk("b_hs_width", c - hs_rise, 6);
         if (!b_vs && prev_vs) begin chk("b_vs_offset", c - last_fs, 160); vs_rise = c; end
         if (b_vs && !prev_vs) chk("b_vs_width", c - vs_rise, 64);
         prev_hs = b_hs; prev_vs = b_vs; prev_ls = b_ls;
      end
      chk("b_fs_count", nfs, 3);
      ce_b = 1'b0;

      // Vertical-blank interrupt: set on pixel (15,3) = 64th ce edge after reset
      nrst = 1'b0; ce_a = 1'b1; ack_a = 1'b0; tick();
      nrst = 1'b1;
      for (int c = 0; c < 63; c++) tick();
      chk("irq_before_set", a_irq, 0);
      tick();
`ifdef VTG_VBLANK_IRQ_EN
      chk("irq_set", a_irq, 1);
      ce_a = 1'b0; ack_a = 1'b1; tick();
      chk("irq_ack_no_ce", a_irq, 0);
      ack_a = 1'b0; ce_a = 1'b1;
      for (int c = 0; c < 127; c++) tick();
      chk("irq_quiet", a_irq, 0);
      ack_a = 1'b1; tick();
      chk("irq_set_beats_ack", a_irq, 1);
      ack_a = 1'b0; ce_a = 1'b0; tick();
      chk("irq_sticky", a_irq, 1);
      ack_a = 1'b1; tick();
      chk("irq_ack_clear", a_irq, 0);
      ack_a = 1'b0;
`else
      chk("irq_disabled", a_irq, 0);
      ack_a = 1'b1; tick();
      chk("irq_disabled_ack", a_irq, 0);
      ack_a = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
